// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// datapath select codes, opcode/funct values and the decoder's class bundle.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EXE  = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [1:0] NPC_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    localparam logic [1:0] AREG_RS    = 2'd0;
    localparam logic [1:0] AREG_SHAMT = 2'd1;

    localparam logic [1:0] GPR_RD  = 2'd0;
    localparam logic [1:0] GPR_RT  = 2'd1;
    localparam logic [1:0] GPR_R31 = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    // Instruction classes that change the FSM path; at most one is set.
    typedef struct packed {
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic jr;
        logic jalr;
    } instClass_t;

    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       pcWrite;
        logic       regWrite;
        logic       extOp;
        logic       aluSrc;
        logic [3:0] aluOp;
        logic [1:0] npcOp;
        logic [1:0] aRegSel;
        logic [1:0] gprSel;
        logic [1:0] wdSel;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Purely combinational Op/Funct decode: instruction class one-hots plus the
// static datapath selects that the FSM exposes in EXE, MEM and WB.
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [5:0]  funct_i,
    output instClass_t  cls_o,
    output logic        extOp_o,
    output logic        aluSrc_o,
    output logic [3:0]  aluOp_o,
    output logic [1:0]  aRegSel_o,
    output logic [1:0]  gprSel_o,
    output logic [1:0]  wdSel_o,
    output logic        regWrite_o,
    output logic        illegal_o
);

    always_comb begin
        cls_o      = '0;
        extOp_o    = 1'b0;
        aluSrc_o   = 1'b0;
        aluOp_o    = ALU_NOP;
        aRegSel_o  = AREG_RS;
        gprSel_o   = GPR_RD;
        wdSel_o    = WD_ALU;
        regWrite_o = 1'b0;
        illegal_o  = 1'b0;

        case (op_i)
            OP_RTYPE: begin
                regWrite_o = 1'b1;
                case (funct_i)
                    F_ADD, F_ADDU: aluOp_o = ALU_ADD;
                    F_SUB, F_SUBU: aluOp_o = ALU_SUB;
                    F_AND:         aluOp_o = ALU_AND;
                    F_OR:          aluOp_o = ALU_OR;
                    F_SLT:         aluOp_o = ALU_SLT;
                    F_SLTU:        aluOp_o = ALU_SLTU;
                    F_SLL: begin
                        aluOp_o   = ALU_SLL;
                        aRegSel_o = AREG_SHAMT;
                    end
                    F_SRL: begin
                        aluOp_o   = ALU_SRL;
                        aRegSel_o = AREG_SHAMT;
                    end
                    F_SRA: begin
                        aluOp_o   = ALU_SRA;
                        aRegSel_o = AREG_SHAMT;
                    end
                    F_JR: begin
                        cls_o.jr   = 1'b1;
                        regWrite_o = 1'b0;
                    end
                    F_JALR: begin
                        cls_o.jalr = 1'b1;
                        gprSel_o   = GPR_R31;
                        wdSel_o    = WD_PC;
                    end
                    default: begin
                        regWrite_o = 1'b0;
                        illegal_o  = 1'b1;
                    end
                endcase
            end
            OP_J:   cls_o.j = 1'b1;
            OP_JAL: begin
                cls_o.jal  = 1'b1;
                regWrite_o = 1'b1;
                gprSel_o   = GPR_R31;
                wdSel_o    = WD_PC;
            end
            OP_BEQ: begin
                cls_o.beq = 1'b1;
                aluOp_o   = ALU_SUB;
            end
            OP_BNE: begin
                cls_o.bne = 1'b1;
                aluOp_o   = ALU_SUB;
            end
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_ORI, OP_LUI: begin
                regWrite_o = 1'b1;
                gprSel_o   = GPR_RT;
                aluSrc_o   = 1'b1;
                // ori and lui take a zero-extended immediate.
                extOp_o    = (op_i != OP_ORI) && (op_i != OP_LUI);
                case (op_i)
                    OP_ADDI:  aluOp_o = ALU_ADD;
                    OP_SLTI:  aluOp_o = ALU_SLT;
                    OP_SLTIU: aluOp_o = ALU_SLTU;
                    OP_ORI:   aluOp_o = ALU_OR;
                    default:  aluOp_o = ALU_LUI;
                endcase
            end
            OP_LW: begin
                cls_o.lw   = 1'b1;
                regWrite_o = 1'b1;
                gprSel_o   = GPR_RT;
                wdSel_o    = WD_MEM;
                aluOp_o    = ALU_ADD;
                aluSrc_o   = 1'b1;
                extOp_o    = 1'b1;
            end
            OP_SW: begin
                cls_o.sw = 1'b1;
                aluOp_o  = ALU_ADD;
                aluSrc_o = 1'b1;
                extOp_o  = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EXE/MEM/WB) with a mem_ready handshake,
// a per-visit wait watchdog that halts the machine, and a sticky error flag.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W  = 4,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_EN  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               EXTOp,
    output logic               ALUSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         NPCOp,
    output logic [1:0]         ARegSel,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic [2:0]         state_o,
    output logic               err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    state_e            state_q, state_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;

    instClass_t        cls;
    logic              decExtOp, decAluSrc, decRegWrite, decIllegal;
    logic [3:0]        decAluOp;
    logic [1:0]        decARegSel, decGprSel, decWdSel;
    logic              memReady, waitExpired;
    ctrl_t             ctrl;

    mc_ctrl_dec u_dec (
        .op_i       (Op),
        .funct_i    (Funct),
        .cls_o      (cls),
        .extOp_o    (decExtOp),
        .aluSrc_o   (decAluSrc),
        .aluOp_o    (decAluOp),
        .aRegSel_o  (decARegSel),
        .gprSel_o   (decGprSel),
        .wdSel_o    (decWdSel),
        .regWrite_o (decRegWrite),
        .illegal_o  (decIllegal)
    );

    assign memReady    = (WAIT_EN != 0) ? mem_ready : 1'b1;
    // This stall cycle would be the MAX_WAIT-th of the current IF/MEM visit.
    assign waitExpired = (waitCnt_q >= CNT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IF;
            err_q     <= 1'b0;
            waitCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        waitCnt_d = waitCnt_q;
        ctrl      = '0;

        if (state_q == ST_EXE || state_q == ST_MEM || state_q == ST_WB) begin
            ctrl.extOp   = decExtOp;
            ctrl.aluSrc  = decAluSrc;
            ctrl.aluOp   = decAluOp;
            ctrl.aRegSel = decARegSel;
            ctrl.gprSel  = decGprSel;
            ctrl.wdSel   = decWdSel;
        end

        case (state_q)
            ST_IF: begin
                ctrl.memRead = 1'b1;
                if (memReady) begin
                    ctrl.irWrite = 1'b1;
                    state_d      = ST_ID;
                end else if (waitExpired) begin
                    err_d     = 1'b1;
                    waitCnt_d = CNT_W'(MAX_WAIT);
                    state_d   = ST_HALT;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            ST_ID: begin
                if (cls.j || cls.jal || cls.jr || cls.jalr) begin
                    ctrl.pcWrite = 1'b1;
                    ctrl.npcOp   = (cls.jr || cls.jalr) ? NPC_JR : NPC_JUMP;
                    if (cls.jal || cls.jalr) begin
                        ctrl.regWrite = 1'b1;
                        ctrl.gprSel   = GPR_R31;
                        ctrl.wdSel    = WD_PC;
                    end
                    state_d = ST_IF;
                end else if (decIllegal) begin
                    // Retire the bad word as a NOP so the program keeps running.
                    err_d        = 1'b1;
                    ctrl.pcWrite = 1'b1;
                    ctrl.npcOp   = NPC_PLUS4;
                    state_d      = ST_IF;
                end else begin
                    state_d = ST_EXE;
                end
            end
            ST_EXE: begin
                if (cls.beq || cls.bne) begin
                    ctrl.pcWrite = 1'b1;
                    ctrl.npcOp   = ((cls.beq && Zero) || (cls.bne && !Zero)) ? NPC_BRANCH : NPC_PLUS4;
                    state_d      = ST_IF;
                end else if (cls.lw || cls.sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                ctrl.memRead  = cls.lw;
                ctrl.memWrite = cls.sw;
                if (memReady) begin
                    if (cls.sw) begin
                        ctrl.pcWrite = 1'b1;
                        ctrl.npcOp   = NPC_PLUS4;
                        state_d      = ST_IF;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (waitExpired) begin
                    err_d     = 1'b1;
                    waitCnt_d = CNT_W'(MAX_WAIT);
                    state_d   = ST_HALT;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            ST_WB: begin
                ctrl.regWrite = decRegWrite;
                ctrl.pcWrite  = 1'b1;
                ctrl.npcOp    = NPC_PLUS4;
                state_d       = ST_IF;
            end
            ST_HALT: ;
            default: state_d = ST_IF;
        endcase

        if (state_d != state_q && (state_d == ST_IF || state_d == ST_MEM)) begin
            waitCnt_d = '0;
        end

        // Reset must kill any in-flight write in the very cycle it is raised.
        if (rst) begin
            ctrl = '0;
        end
    end

    assign MemRead  = ctrl.memRead;
    assign MemWrite = ctrl.memWrite;
    assign IRWrite  = ctrl.irWrite;
    assign PCWrite  = ctrl.pcWrite;
    assign RegWrite = ctrl.regWrite;
    assign EXTOp    = ctrl.extOp;
    assign ALUSrc   = ctrl.aluSrc;
    assign ALUOp    = ALUOP_W'(ctrl.aluOp);
    assign NPCOp    = ctrl.npcOp;
    assign ARegSel  = ctrl.aRegSel;
    assign GPRSel   = ctrl.gprSel;
    assign WDSel    = ctrl.wdSel;
    assign state_o  = rst ? 3'd0 : 3'(state_q);
    assign err      = err_q & ~rst;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each driven cycle queues a hand-computed
// output snapshot that an independent negedge monitor pops and compares.
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       mr, mw, ir, pcw, rw, ext, asrc;
        logic [3:0] alu;
        logic [1:0] npc, areg, gpr, wd;
        logic       err;
    } obs_t;

    typedef struct {
        string name;
        obs_t  e;
    } item_t;

    logic       clk, rst, Zero, mem_ready;
    logic [5:0] Op, Funct;
    logic       MemRead, MemWrite, IRWrite, PCWrite, RegWrite, EXTOp, ALUSrc;
    logic [3:0] ALUOp;
    logic [1:0] NPCOp, ARegSel, GPRSel, WDSel;
    logic [2:0] state_o;
    logic       err;
    obs_t       act;

    item_t sb[$];
    int    total = 0;
    int    bad   = 0;

    mc_ctrl #(.ALUOP_W(4), .MAX_WAIT(15), .WAIT_EN(1)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .NPCOp(NPCOp),
        .ARegSel(ARegSel), .GPRSel(GPRSel), .WDSel(WDSel), .state_o(state_o), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act = {state_o, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, EXTOp, ALUSrc,
                  ALUOp, NPCOp, ARegSel, GPRSel, WDSel, err};

    // Strobe order in s: MemRead MemWrite IRWrite PCWrite RegWrite EXTOp ALUSrc.
    function automatic obs_t ob(input logic [2:0] st, input logic [6:0] s, input logic [3:0] alu,
                                input logic [1:0] npc, input logic [1:0] areg,
                                input logic [1:0] gpr, input logic [1:0] wd, input logic e);
        return {st, s, alu, npc, areg, gpr, wd, e};
    endfunction

    task automatic checkOutput(input string name, input obs_t e, input obs_t a);
        total++;
        if (a !== e) begin
            bad++;
            $display("[TB] FAIL %s: got=%06h (state %0d) expected=%06h (state %0d)",
                     name, a, a.st, e, e.st);
        end
    endtask

    always @(negedge clk) begin
        item_t it;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            checkOutput(it.name, it.e, act);
        end
    end

    task automatic applyStimulus(input string name, input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic rdy, input logic rs, input obs_t e);
        item_t it;
        Op        = op;
        Funct     = fn;
        Zero      = z;
        mem_ready = rdy;
        rst       = rs;
        it.name   = name;
        it.e      = e;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic fetchCycle(input string name, input logic [5:0] op, input logic [5:0] fn,
                              input logic e);
        applyStimulus(name, op, fn, 1'b0, 1'b1, 1'b0, ob(3'd0, 7'b1010000, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, e));
    endtask

    initial begin
        rst = 1'b1; Op = 6'h00; Funct = 6'h20; Zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus("reset", 6'h00, 6'h20, 0, 1, 1, ob(3'd0, 7'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));

        // add: IF ID EXE WB
        fetchCycle("add IF", 6'h00, 6'h20, 0);
        applyStimulus("add ID", 6'h00, 6'h20, 0, 1, 0, ob(3'd1, 7'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        applyStimulus("add EXE", 6'h00, 6'h20, 0, 1, 0, ob(3'd2, 7'b0, 4'd1, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        applyStimulus("add WB", 6'h00, 6'h20, 0, 1, 0, ob(3'd4, 7'b0001100, 4'd1, 2'd0, 2'd0, 2'd0, 2'd0, 0));

        // lw with three stall cycles in MEM
        fetchCycle("lw IF", 6'h23, 6'h00, 0);
        applyStimulus("lw ID", 6'h23, 6'h00, 0, 1, 0, ob(3'd1, 7'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        applyStimulus("lw EXE", 6'h23, 6'h00, 0, 1, 0, ob(3'd2, 7'b0000011, 4'd1, 2'd0, 2'd0, 2'd1, 2'd1, 0));
        for (int i = 0; i < 3; i++)
            applyStimulus("lw MEM stall", 6'h23, 6'h00, 0, 0, 0, ob(3'd3, 7'b1000011, 4'd1, 2'd0, 2'd0, 2'd1, 2'd1, 0));
        applyStimulus("lw MEM done", 6'h23, 6'h00, 0, 1, 0, ob(3'd3, 7'b1000011, 4'd1, 2'd0, 2'd0, 2'd1, 2'd1, 0));
        applyStimulus("lw WB", 6'h23, 6'h00, 0, 1, 0, ob(3'd4, 7'b0001111, 4'd1, 2'd0, 2'd0, 2'd1, 2'd1, 0));

        // beq taken / not taken, bne taken
        fetchCycle("beq1 IF", 6'h04, 6'h00, 0);
        applyStimulus("beq1 ID", 6'h04, 6'h00, 1, 1, 0, ob(3'd1, 7'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        applyStimulus("beq taken", 6'h04, 6'h00, 1, 1, 0, ob(3'd2, 7'b0001000, 4'd2, 2'd1, 2'd0, 2'd0, 2'd0, 0));
        fetchCycle("beq0 IF", 6'h04, 6'h00, 0);
        applyStimulus("beq0 ID", 6'h04, 6'h00, 0, 1, 0, ob(3'd1, 7'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        applyStimulus("beq not taken", 6'h04, 6'h00, 0, 1, 0, ob(3'd2, 7'b0001000, 4'd2, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        fetchCycle("bne IF", 6'h05, 6'h00, 0);
        applyStimulus("bne ID", 6'h05, 6'h00, 0, 1, 0, ob(3'd1, 7'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        applyStimulus("bne taken", 6'h05, 6'h00, 0, 1, 0, ob(3'd2, 7'b0001000, 4'd2, 2'd1, 2'd0, 2'd0, 2'd0, 0));

        // jal and jr resolve in ID
        fetchCycle("jal IF", 6'h03, 6'h00, 0);
        applyStimulus("jal ID", 6'h03, 6'h00, 0, 1, 0, ob(3'd1, 7'b0001100, 4'd0, 2'd2, 2'd0, 2'd2, 2'd2, 0));
        fetchCycle("jr IF", 6'h00, 6'h08, 0);
        applyStimulus("jr ID", 6'h00, 6'h08, 0, 1, 0, ob(3'd1, 7'b0001000, 4'd0, 2'd3, 2'd0, 2'd0, 2'd0, 0));

        // ori zero-extends, writes rt
        fetchCycle("ori IF", 6'h0D, 6'h00, 0);
        applyStimulus("ori ID", 6'h0D, 6'h00, 0, 1, 0, ob(3'd1, 7'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        applyStimulus("ori EXE", 6'h0D, 6'h00, 0, 1, 0, ob(3'd2, 7'b0000001, 4'd4, 2'd0, 2'd0, 2'd1, 2'd0, 0));
        applyStimulus("ori WB", 6'h0D, 6'h00, 0, 1, 0, ob(3'd4, 7'b0001101, 4'd4, 2'd0, 2'd0, 2'd1, 2'd0, 0));

        // sll uses shamt for A
        fetchCycle("sll IF", 6'h00, 6'h00, 0);
        applyStimulus("sll ID", 6'h00, 6'h00, 0, 1, 0, ob(3'd1, 7'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        applyStimulus("sll EXE", 6'h00, 6'h00, 0, 1, 0, ob(3'd2, 7'b0, 4'd8, 2'd0, 2'd1, 2'd0, 2'd0, 0));
        applyStimulus("sll WB", 6'h00, 6'h00, 0, 1, 0, ob(3'd4, 7'b0001100, 4'd8, 2'd0, 2'd1, 2'd0, 2'd0, 0));

        // sw retires from MEM
        fetchCycle("sw IF", 6'h2B, 6'h00, 0);
        applyStimulus("sw ID", 6'h2B, 6'h00, 0, 1, 0, ob(3'd1, 7'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        applyStimulus("sw EXE", 6'h2B, 6'h00, 0, 1, 0, ob(3'd2, 7'b0000011, 4'd1, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        applyStimulus("sw MEM", 6'h2B, 6'h00, 0, 1, 0, ob(3'd3, 7'b0101011, 4'd1, 2'd0, 2'd0, 2'd0, 2'd0, 0));

        // illegal opcode: NOP with PC+4, err sticks, next add runs normally
        fetchCycle("ill IF", 6'h3F, 6'h00, 0);
        applyStimulus("ill ID", 6'h3F, 6'h00, 0, 1, 0, ob(3'd1, 7'b0001000, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        fetchCycle("add2 IF", 6'h00, 6'h20, 1);
        applyStimulus("add2 ID", 6'h00, 6'h20, 0, 1, 0, ob(3'd1, 7'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1));
        applyStimulus("add2 EXE", 6'h00, 6'h20, 0, 1, 0, ob(3'd2, 7'b0, 4'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1));
        applyStimulus("add2 WB", 6'h00, 6'h20, 0, 1, 0, ob(3'd4, 7'b0001100, 4'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1));

        // reset raised while sw is stalled in MEM
        fetchCycle("sw2 IF", 6'h2B, 6'h00, 1);
        applyStimulus("sw2 ID", 6'h2B, 6'h00, 0, 1, 0, ob(3'd1, 7'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1));
        applyStimulus("sw2 EXE", 6'h2B, 6'h00, 0, 1, 0, ob(3'd2, 7'b0000011, 4'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1));
        applyStimulus("sw2 MEM stall", 6'h2B, 6'h00, 0, 0, 0, ob(3'd3, 7'b0100011, 4'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1));
        applyStimulus("sw2 MEM rst", 6'h2B, 6'h00, 0, 0, 1, ob(3'd0, 7'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));

        // fetch never completes: 15 stall cycles then HALT
        for (int i = 0; i < 15; i++)
            applyStimulus("IF stall", 6'h00, 6'h20, 0, 0, 0, ob(3'd0, 7'b1000000, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        for (int i = 0; i < 3; i++)
            applyStimulus("HALT", 6'h00, 6'h20, 0, 1, 0, ob(3'd5, 7'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1));
        applyStimulus("HALT rst", 6'h00, 6'h20, 0, 1, 1, ob(3'd0, 7'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        fetchCycle("post-rst IF", 6'h00, 6'h20, 0);
        applyStimulus("post-rst ID", 6'h00, 6'h20, 0, 1, 0, ob(3'd1, 7'b0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0));

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control unit for the MIPS datapath.
- Replaces single-cycle decode with an IF/ID/EXE/MEM/WB state machine, so one ALU and one memory port are shared across cycles.
- Supports variable-latency memory via a mem_ready handshake, with a watchdog timeout.
- Sits between the instruction register (Op/Funct) and the datapath muxes, PC, register file and memory.

Parameters:
- ALUOP_W, 4, width of ALUOp; codes zero-extended to this width.
- MAX_WAIT, 15, max cycles spent waiting on mem_ready in one IF or MEM visit before error.
- WAIT_EN, 1, 1 = honour mem_ready; 0 = treat mem_ready as always 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- Op  in  6  opcode from IR
- Funct  in  6  funct from IR
- Zero  in  1  ALU zero flag, sampled in EXE
- mem_ready  in  1  memory completes the current access this cycle
- MemRead  out  1  memory read request (IF fetch or lw)
- MemWrite  out  1  memory write request (sw)
- IRWrite  out  1  load IR
- PCWrite  out  1  load PC from NPC
- RegWrite  out  1  register file write
- EXTOp  out  1  1 = sign-extend immediate
- ALUSrc  out  1  ALU B from immediate
- ALUOp  out  ALUOP_W  NOP=0, ADD=1, SUB=2, AND=3, OR=4, SLT=5, SLTU=6, SLL=8, SRL=9, SRA=10, LUI=11
- NPCOp  out  2  PLUS4=0, BRANCH=1, JUMP=2, JR=3
- ARegSel  out  2  RS=0, SHAMT=1
- GPRSel  out  2  RD=0, RT=1, R31=2
- WDSel  out  2  ALU=0, MEM=1, PC=2
- state_o  out  3  current state, for debug
- err  out  1  sticky error flag

Behaviour:
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5, held in a 3-bit register.
- Reset (rst high at clk edge): state=IF, err=0, wait counter=0.
  - While rst is high, every control output is forced to 0 and state_o reads 0.
- Outputs are combinational from state, decoded class and Zero.
  - Any output not listed for a state is 0.
  - Decode outputs (EXTOp, ALUSrc, ALUOp, ARegSel, GPRSel, WDSel) are valid in EXE, MEM and WB.
- IF:
  - MemRead=1.
  - mem_ready=1: IRWrite=1, go to ID.
  - Otherwise stay in IF and increment the wait counter.
- ID:
  - j: PCWrite=1, NPCOp=JUMP, go to IF.
  - jal: RegWrite=1, GPRSel=R31, WDSel=PC, PCWrite=1, NPCOp=JUMP, go to IF.
  - jr: PCWrite=1, NPCOp=JR, go to IF.
  - jalr: as jal but with NPCOp=JR.
  - Illegal opcode/funct: err<=1, PCWrite=1, NPCOp=PLUS4, go to IF (executed as a NOP).
  - All other instructions: go to EXE.
- EXE:
  - beq/bne: ALUOp=SUB. PCWrite=1; NPCOp=BRANCH if (beq&Zero)|(bne&~Zero), else PLUS4. Go to IF.
  - lw/sw: ALUOp=ADD, ALUSrc=1, EXTOp=1, go to MEM.
  - All others: go to WB.
- MEM:
  - lw: MemRead=1; on mem_ready go to WB.
  - sw: MemWrite=1; on mem_ready set PCWrite=1, NPCOp=PLUS4, go to IF.
  - No mem_ready: hold all outputs and increment the wait counter.
- WB:
  - RegWrite=1, PCWrite=1, NPCOp=PLUS4, go to IF.
  - GPRSel: RD for R-type; RT for addi/ori/slti/sltiu/lui/lw.
  - WDSel: MEM for lw, else ALU.
- Register-writing set: all R-type ALU ops (including shifts), addi, ori, slti, sltiu, lui, lw, jal, jalr.
- EXTOp=1 for addi, slti, sltiu, lw, sw. ori and lui zero-extend.
- ARegSel=SHAMT for sll, srl, sra.
- Wait counter:
  - Cleared on entry to IF and to MEM.
  - Saturates at MAX_WAIT. When it reaches MAX_WAIT without mem_ready: err<=1, go to HALT.
- HALT: all outputs 0; remain until rst.
- err is sticky; cleared only by rst.
- Latency in cycles with mem_ready always 1:
  - j/jal/jr/jalr: 2
  - beq/bne: 3
  - R-type/immediate: 4
  - sw: 4
  - lw: 5
- rst mid-instruction: abort the instruction with no further PCWrite/RegWrite/MemWrite; restart at IF.

Decomposition:
- mc_ctrl_pkg holds:
  - state encoding
  - ALUOp, NPCOp, GPRSel, WDSel and ARegSel constants
  - opcode and funct constants
- Sub-module mc_ctrl_dec: purely combinational Op/Funct decode.
  - Produces instruction-class one-hots plus EXTOp, ALUSrc, ALUOp, ARegSel, GPRSel, WDSel, RegWrite-class and illegal.
  - mc_ctrl owns the FSM, the wait counter and output gating.

Test Plan:
- rst, then add (Op=0, Funct=0x20) with mem_ready=1 -> states IF,ID,EXE,WB,IF. RegWrite=1 only in WB with GPRSel=0, ALUOp=1. PCWrite once, with NPCOp=0.
- lw (Op=0x23) with mem_ready low for 3 cycles in MEM -> MemRead held 4 cycles, then WB with WDSel=1, GPRSel=1. Total 8 cycles; err=0.
- beq (Op=0x04) with Zero=1, then with Zero=0 -> PCWrite in EXE with NPCOp=1, then NPCOp=0. RegWrite never asserted.
- jal (Op=0x03) -> in ID: RegWrite=1, GPRSel=2, WDSel=2, NPCOp=2, PCWrite=1. Next state IF.
- mem_ready held 0 in IF, MAX_WAIT=15 -> HALT reached after 15 wait cycles with err=1. All outputs 0 until rst; after rst, state_o=0 and err=0.
- Op=0x3F (illegal) -> err=1, PC+4, next instruction executes normally. rst asserted during MEM of sw -> MemWrite drops the same cycle; state IF after the edge.
